// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between multicycle_controller and the memories/datapath.
// Controller side uses modport master; the memory/datapath side uses modport slave.
interface multicycle_controller_if #(
  parameter int ALUOP_W = 2
);
  // Handshake: imem_req stays high for the whole FETCH state and a word is taken
  // in any cycle where imem_req and imem_ready are both 1. mem_read/mem_write stay
  // high until dmem_ready; the access completes in the cycle both are 1.
  logic [31:0]        inst;
  logic               imem_ready;
  logic               dmem_ready;
  logic               br_cond;
  logic               imem_req;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic               branch;
  logic               mem_read;
  logic               mem_write;
  logic [1:0]         mem_to_reg;
  logic               alu_src_a;
  logic               alu_src;
  logic               reg_write;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         fault;
  logic [2:0]         state;

  modport master (
    input  inst, imem_ready, dmem_ready, br_cond,
    output imem_req, ir_write, pc_write, pc_src, branch, mem_read, mem_write,
           mem_to_reg, alu_src_a, alu_src, reg_write, alu_op, fault, state
  );

  modport slave (
    output inst, imem_ready, dmem_ready, br_cond,
    input  imem_req, ir_write, pc_write, pc_src, branch, mem_read, mem_write,
           mem_to_reg, alu_src_a, alu_src, reg_write, alu_op, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory wait timeouts.
// Define CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int ALUOP_W = 2
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  // Trap fires in the cycle that would make the TIMEOUT-th consecutive wait.
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q;
  logic [1:0]    fault_q;
  logic [CW-1:0] wait_cnt;
  logic [6:0]    opcode_q;
  logic [2:0]    funct3_q;
  logic          timeout_hit;
  logic          pc_write_c;
  logic [1:0]    aop;
  logic          unused_inst;

  assign unused_inst = ^{bus.inst[31:15], bus.inst[11:7]};
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == LIMIT);

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      OP_BRANCH: return (f3 != 3'b010) && (f3 != 3'b011);
      default:   return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      fault_q  <= 2'b00;
      wait_cnt <= '0;
      opcode_q <= '0;
      funct3_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            opcode_q <= bus.inst[6:0];
            funct3_q <= bus.inst[14:12];
            state_q  <= S_DECODE;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state_q  <= S_TRAP;
            fault_q  <= 2'b10;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (is_legal(opcode_q, funct3_q)) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_TRAP;
            fault_q <= 2'b01;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            OP_BRANCH:         state_q <= S_FETCH;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            state_q  <= (opcode_q == OP_LOAD) ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state_q  <= S_TRAP;
            fault_q  <= 2'b11;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    pc_write_c     = 1'b0;
    bus.pc_src     = 2'b00;
    bus.branch     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src    = 1'b0;
    bus.reg_write  = 1'b0;
    aop            = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R:      aop = 2'b10;
          OP_I: begin
            aop         = 2'b11;
            bus.alu_src = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JALR, OP_LUI: bus.alu_src = 1'b1;
          OP_AUIPC: begin
            bus.alu_src   = 1'b1;
            bus.alu_src_a = 1'b1;
          end
          OP_BRANCH: begin
            aop        = 2'b01;
            bus.branch = 1'b1;
            pc_write_c = 1'b1;
            bus.pc_src = bus.br_cond ? 2'b01 : 2'b00;
          end
          default: aop = 2'b00;
        endcase
      end
      S_MEM: begin
        bus.mem_read  = (opcode_q == OP_LOAD);
        bus.mem_write = (opcode_q == OP_STORE);
        bus.alu_src   = 1'b1;
        pc_write_c    = (opcode_q == OP_STORE) && bus.dmem_ready;
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        pc_write_c    = 1'b1;
        case (opcode_q)
          OP_LOAD:          bus.mem_to_reg = 2'b01;
          OP_JAL, OP_JALR:  bus.mem_to_reg = 2'b10;
          OP_LUI:           bus.mem_to_reg = 2'b11;
          default:          bus.mem_to_reg = 2'b00;
        endcase
        if (opcode_q == OP_JAL)       bus.pc_src = 2'b01;
        else if (opcode_q == OP_JALR) bus.pc_src = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.pc_write = pc_write_c;
  assign bus.alu_op   = ALUOP_W'(aop);
  assign bus.fault    = fault_q;
  assign bus.state    = state_q;

`ifdef CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_write_c)        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: instruction classes, memory waits,
// timeouts, illegal-instruction trap and mid-instruction reset.
module tb_multicycle_controller;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [2:0] exp_q[$];

  multicycle_controller_if #(.ALUOP_W(2)) bus ();

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  multicycle_controller #(.TIMEOUT(16), .ALUOP_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ctl();
    return {bus.ir_write, bus.pc_write, bus.pc_src, bus.branch, bus.mem_read, bus.mem_write,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src, bus.reg_write, bus.alu_op};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_cond    = 1'b0;
    bus.inst       = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [2:0] s);
    exp_q.push_back(s);
  endtask

  // Drive one cycle's inputs, let outputs settle, compare state with the scoreboard.
  task automatic cyc(input logic ir, input logic dr, input logic bc);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    bus.br_cond    = bc;
    #1;
    if (exp_q.size() != 0) check("state_seq", 32'(bus.state), 32'(exp_q.pop_front()));
  endtask

  task automatic run_simple(input string nm, input logic [31:0] w, input logic chk_alu,
                            input logic [1:0] aop, input logic asrc, input logic asrca,
                            input logic [1:0] m2r, input logic [1:0] psrc);
    bus.inst = w;
    push(3'd0); push(3'd1); push(3'd2); push(3'd4);
    cyc(1'b1, 1'b0, 1'b0);
    check({nm, "_ir_write"}, 32'(bus.ir_write), 32'd1);
    step();
    cyc(1'b0, 1'b0, 1'b0);
    step();
    cyc(1'b0, 1'b0, 1'b0);
    if (chk_alu) begin
      check({nm, "_alu_op"}, 32'(bus.alu_op), 32'(aop));
      check({nm, "_alu_src"}, 32'(bus.alu_src), 32'(asrc));
      check({nm, "_alu_src_a"}, 32'(bus.alu_src_a), 32'(asrca));
    end
    step();
    cyc(1'b0, 1'b0, 1'b0);
    check({nm, "_wb_reg_write"}, 32'(bus.reg_write), 32'd1);
    check({nm, "_wb_pc_write"}, 32'(bus.pc_write), 32'd1);
    check({nm, "_wb_mem_to_reg"}, 32'(bus.mem_to_reg), 32'(m2r));
    check({nm, "_wb_pc_src"}, 32'(bus.pc_src), 32'(psrc));
    step();
    check({nm, "_back_fetch"}, 32'(bus.state), 32'd0);
  endtask

  task automatic run_branch(input logic bc);
    int rw_seen;
    rw_seen = 0;
    bus.inst = 32'h00208463;
    push(3'd0); push(3'd1); push(3'd2);
    cyc(1'b1, 1'b0, bc); rw_seen += int'(bus.reg_write); step();
    cyc(1'b0, 1'b0, bc); rw_seen += int'(bus.reg_write); step();
    cyc(1'b0, 1'b0, bc); rw_seen += int'(bus.reg_write);
    check("beq_branch", 32'(bus.branch), 32'd1);
    check("beq_pc_write", 32'(bus.pc_write), 32'd1);
    check("beq_pc_src", 32'(bus.pc_src), bc ? 32'd1 : 32'd0);
    check("beq_alu_op", 32'(bus.alu_op), 32'd1);
    step();
    check("beq_next_fetch", 32'(bus.state), 32'd0);
    check("beq_no_reg_write", 32'(rw_seen), 32'd0);
  endtask

  task automatic run_illegal(input string nm, input logic [31:0] w);
    bus.inst = w;
    push(3'd0); push(3'd1); push(3'd5);
    cyc(1'b1, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0);
    check({nm, "_fault"}, 32'(bus.fault), 32'd1);
    check({nm, "_imem_req"}, 32'(bus.imem_req), 32'd0);
  endtask

  // main sequence
  initial begin
    int cnt;
    n_cmp = 0;
    n_bad = 0;

    do_reset();
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd1);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_ctl", 32'(ctl()), 32'd0);
`ifdef CTRL_PERF_EN
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_instret_cnt", instret_cnt, 32'd0);
`endif

    run_simple("add", 32'h002081B3, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
`ifdef CTRL_PERF_EN
    check("add_cycle_cnt", cycle_cnt, 32'd4);
    check("add_instret_cnt", instret_cnt, 32'd1);
`endif
    run_simple("addi",  32'h00108093, 1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00);
    run_simple("jal",   32'h008000EF, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b01);
    run_simple("jalr",  32'h000080E7, 1'b1, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10);
    run_simple("lui",   32'h123452B7, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    run_simple("auipc", 32'h00001297, 1'b1, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00);

    // lw with dmem_ready on the 4th MEM cycle
    bus.inst = 32'h0080A283;
    cnt = 0;
    push(3'd0); push(3'd1); push(3'd2);
    push(3'd3); push(3'd3); push(3'd3); push(3'd3); push(3'd4);
    cyc(1'b1, 1'b0, 1'b0); cnt += int'(bus.mem_read); step();
    cyc(1'b0, 1'b0, 1'b0); cnt += int'(bus.mem_read); step();
    cyc(1'b0, 1'b0, 1'b0); cnt += int'(bus.mem_read);
    check("lw_alu_src", 32'(bus.alu_src), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i == 3), 1'b0);
      cnt += int'(bus.mem_read);
      step();
    end
    cyc(1'b0, 1'b0, 1'b0); cnt += int'(bus.mem_read);
    check("lw_wb_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
    check("lw_wb_reg_write", 32'(bus.reg_write), 32'd1);
    step();
    check("lw_mem_read_cycles", 32'(cnt), 32'd4);
    check("lw_back_fetch", 32'(bus.state), 32'd0);

    // sw with zero-wait data memory
    bus.inst = 32'h0050A423;
    push(3'd0); push(3'd1); push(3'd2); push(3'd3);
    cyc(1'b1, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b1, 1'b0);
    check("sw_mem_write", 32'(bus.mem_write), 32'd1);
    check("sw_pc_write", 32'(bus.pc_write), 32'd1);
    check("sw_pc_src", 32'(bus.pc_src), 32'd0);
    step();
    check("sw_back_fetch", 32'(bus.state), 32'd0);

    run_branch(1'b1);
    run_branch(1'b0);

    // illegal opcode: trap held for 20 cycles regardless of inputs
    do_reset();
    run_illegal("illegal_op", 32'hFFFFFFFF);
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (bus.state != 3'd5 || bus.fault != 2'b01 || bus.imem_req || ctl() != 14'd0) cnt++;
      step();
    end
    check("trap_hold_violations", 32'(cnt), 32'd0);
    do_reset();
    #1;
    check("trap_rst_state", 32'(bus.state), 32'd0);
    check("trap_rst_fault", 32'(bus.fault), 32'd0);

    do_reset();
    run_illegal("br_f3_010", 32'h0020A463);
    do_reset();
    run_illegal("br_f3_011", 32'h0020B463);

    // imem timeout after 16 wait cycles
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(3'd0);
      cyc(1'b0, 1'b0, 1'b0);
      step();
    end
    check("imem_to_state", 32'(bus.state), 32'd5);
    check("imem_to_fault", 32'(bus.fault), 32'd2);
    check("imem_to_imem_req", 32'(bus.imem_req), 32'd0);

    // ready arriving at the limit cycle wins
    do_reset();
    for (int i = 0; i < 15; i++) begin
      push(3'd0);
      cyc(1'b0, 1'b0, 1'b0);
      step();
    end
    bus.inst = 32'h002081B3;
    cyc(1'b1, 1'b0, 1'b0);
    check("limit_ir_write", 32'(bus.ir_write), 32'd1);
    step();
    check("limit_state", 32'(bus.state), 32'd1);
    check("limit_fault", 32'(bus.fault), 32'd0);

    // dmem timeout on a store
    do_reset();
    bus.inst = 32'h0050A423;
    push(3'd0); push(3'd1); push(3'd2);
    cyc(1'b1, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 16; i++) begin
      push(3'd3);
      cyc(1'b0, 1'b0, 1'b0);
      step();
    end
    check("dmem_to_state", 32'(bus.state), 32'd5);
    check("dmem_to_fault", 32'(bus.fault), 32'd3);

    // reset on the 2nd MEM cycle of a store
    do_reset();
    bus.inst = 32'h0050A423;
    push(3'd0); push(3'd1); push(3'd2); push(3'd3); push(3'd3);
    cyc(1'b1, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0); step();
    cyc(1'b0, 1'b0, 1'b0);
    check("sw_m1_mem_write", 32'(bus.mem_write), 32'd1);
    step();
    cyc(1'b0, 1'b0, 1'b0);
    check("sw_m2_mem_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_mem_write", 32'(bus.mem_write), 32'd0);
    check("abort_pc_write", 32'(bus.pc_write), 32'd0);
    check("abort_imem_req", 32'(bus.imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RISC-V CPU. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath controls from a latched copy of the instruction fields. It handshakes with instruction and data memories that have variable latency, and covers RV32I opcodes R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC. It sits between the memories and the datapath (PC, register file, ALU) and replaces single-cycle decode.

Parameters:
TIMEOUT, 16, maximum cycles spent waiting on imem_ready or dmem_ready before a fault; 0 disables the timeout.
ALUOP_W, 2, width of alu_op; upper bits are zero when greater than 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
inst  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  instruction memory has data this cycle
dmem_ready  in  1  data memory has completed the access this cycle
br_cond  in  1  ALU branch comparison result (1 = taken), sampled in EXEC
imem_req  out  1  instruction fetch request
ir_write  out  1  datapath latches inst into the IR
pc_write  out  1  PC update strobe
pc_src  out  2  00 pc+4; 01 pc+imm (branch, JAL); 10 ALU result with lsb cleared (JALR)
branch  out  1  branch instruction in EXEC
mem_read  out  1  load access
mem_write  out  1  store access
mem_to_reg  out  2  00 ALU; 01 memory; 10 pc+4; 11 imm (LUI)
alu_src_a  out  1  0 = rs1; 1 = pc (AUIPC)
alu_src  out  1  0 = rs2; 1 = imm
reg_write  out  1  register file write strobe
alu_op  out  ALUOP_W  00 add (LOAD, STORE, JALR, AUIPC, LUI); 01 branch; 10 R-type; 11 I-type
fault  out  2  00 none; 01 illegal instruction; 10 imem timeout; 11 dmem timeout
state  out  3  current state, for debug

Behaviour:
- Outputs are combinational from the registered state and the internal opcode/funct3 register. Every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- At the rst edge: state=FETCH, fault=00, wait counter=0, opcode register=0.
- Reset output values (FETCH values): imem_req=1, state=0, fault=00, all other outputs 0.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1 in the same cycle, the opcode and funct3 of inst are latched internally, next state DECODE.
- DECODE (1 cycle):
  - Unknown opcode, or BRANCH with funct3 010 or 011, goes to TRAP with fault=01.
  - Otherwise goes to EXEC.
- EXEC (1 cycle): alu_op, alu_src and alu_src_a are driven per instruction class.
  - R, I, LUI, AUIPC, JAL, JALR: next state WB.
  - LOAD, STORE: next state MEM.
  - BRANCH: branch=1, pc_write=1, pc_src=01 if br_cond=1 else 00; next state FETCH. No WB.
- MEM:
  - mem_read (LOAD) or mem_write (STORE) is held, together with alu_op=00 and alu_src=1, until dmem_ready=1.
  - LOAD then goes to WB.
  - STORE asserts pc_write=1 with pc_src=00 in the dmem_ready cycle, then goes to FETCH.
- WB (1 cycle):
  - reg_write=1 and pc_write=1.
  - mem_to_reg: 01 for LOAD, 10 for JAL/JALR, 11 for LUI, else 00.
  - pc_src: 01 for JAL, 10 for JALR, else 00.
  - Next state FETCH. A write to rd=x0 is discarded by the register file, not here.
- TRAP:
  - All control outputs are 0, including imem_req. fault holds its value.
  - The block stays in TRAP until rst.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle in FETCH or MEM while ready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with ready still 0, next state is TRAP with fault=10 (FETCH) or 11 (MEM).
  - A ready arriving in the same cycle as the limit wins; no fault is raised.
- Latency with zero-wait memories: R/I/LUI/AUIPC/JAL/JALR take 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Reset mid-instruction aborts it. mem_read, mem_write and reg_write are 0 from the cycle after the rst edge, and the PC is not updated.
- rst has priority over every transition, including entry into TRAP in the same cycle.

Optional Feature:
CTRL_PERF_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both cleared by rst.
  - cycle_cnt increments every cycle that state≠TRAP.
  - instret_cnt increments on each cycle with pc_write=1.
  - Both wrap modulo 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- add x3,x1,x2 (0x002081B3), imem_ready=1 in the first FETCH cycle -> states 0,1,2,4. In WB: reg_write=1, mem_to_reg=00, pc_write=1, pc_src=00. In EXEC: alu_op=10. Back in FETCH at cycle 5.
- lw x5,8(x1) (0x0080A283), dmem_ready raised on the 4th MEM cycle -> mem_read=1 for exactly 4 cycles, then WB with mem_to_reg=01 and reg_write=1.
- beq x1,x2,8 (0x00208463): br_cond=1 -> in EXEC branch=1, pc_write=1, pc_src=01, next state FETCH, reg_write never 1. Repeat with br_cond=0 -> pc_src=00.
- inst=0xFFFFFFFF -> TRAP after DECODE, fault=01, imem_req=0 held for 20 cycles, cleared only by rst.
- TIMEOUT=16, imem_ready held 0 -> fault=10 and state=5 on the cycle after the 16th wait cycle. The same check with ready arriving exactly at the limit -> no fault.
- sw (0x0050A423), rst pulsed on the 2nd MEM cycle with dmem_ready=0 -> next cycle state=0, mem_write=0, pc_write=0, imem_req=1.
